// File: rtl/sha_const.sv
// Shared constants and types for the sha core and its stream front end.
package sha_const;

    localparam int unsigned Nl = 64;      // message length in bytes
    localparam int unsigned Nk = 256;     // digest width in bits
    localparam int unsigned Nh = Nk / 8;  // digest length in bytes

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        SEND    = 2'd3
    } stream_state_t;

endpackage

// File: rtl/sha_stream.sv
// Byte-stream front end for the sha core: collects Nl bytes, starts the core,
// then serialises the captured digest MSB-first.
module sha_stream
    import sha_const::*;
#(
    parameter int unsigned Nl = sha_const::Nl,
    parameter int unsigned Nk = sha_const::Nk
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    In_Data,
    input  logic          In_Valid,
    output logic          In_Ready,
    output logic [7:0]    Out_Data,
    output logic          Out_Valid,
    input  logic          Out_Ready,
    output logic          Out_Last,
    output logic [7:0]    Sha_Data [0:Nl-1],
    output logic          Sha_Enable,
    input  logic [Nk-1:0] Sha_Hash,
    input  logic          Sha_Ready,
    output logic          Busy
);

    localparam int unsigned HB  = Nk / 8;
    localparam int unsigned ICW = $clog2(Nl + 1);
    localparam int unsigned OCW = $clog2(HB);

    typedef struct packed {
        stream_state_t      state;
        logic [ICW-1:0]     in_cnt;
        logic [OCW-1:0]     out_cnt;
        logic [Nl-1:0][7:0] buffer;
        logic [Nk-1:0]      hash;
    } reg_type;

    reg_type    r_q;
    reg_type    r_d;
    logic       in_open;
    logic       in_fire;
    logic       out_last;
    logic [7:0] out_byte;

    // Input is open while collecting or draining, until the buffer is full.
    always_comb begin
        in_open  = ((r_q.state == COLLECT) || (r_q.state == SEND)) &&
                   (r_q.in_cnt < ICW'(Nl));
        in_fire  = in_open && In_Valid;
        out_last = (r_q.state == SEND) && (r_q.out_cnt == OCW'(HB - 1));
    end

    // Next-state: byte capture, FSM sequencing and digest capture.
    always_comb begin
        r_d = r_q;
        if (in_fire) begin
            for (int i = 0; i < int'(Nl); i++) begin
                if (r_q.in_cnt == ICW'(i)) begin
                    r_d.buffer[i] = In_Data;
                end
            end
            r_d.in_cnt = r_q.in_cnt + ICW'(1);
        end
        case (r_q.state)
            COLLECT: begin
                if (r_q.in_cnt == ICW'(Nl)) begin
                    r_d.state = START;
                end
            end
            START: begin
                r_d.state = WAIT;
            end
            WAIT: begin
                if (Sha_Ready) begin
                    r_d.hash    = Sha_Hash;
                    r_d.in_cnt  = '0;
                    r_d.out_cnt = '0;
                    r_d.state   = SEND;
                end
            end
            SEND: begin
                if (Out_Ready) begin
                    if (out_last) begin
                        r_d.out_cnt = '0;
                        // A message completed during the drain starts at once.
                        r_d.state   = (r_d.in_cnt == ICW'(Nl)) ? START : COLLECT;
                    end else begin
                        r_d.out_cnt = r_q.out_cnt + OCW'(1);
                    end
                end
            end
            default: begin
                r_d.state = COLLECT;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    // Digest byte select, most significant byte first.
    always_comb begin
        out_byte = 8'h00;
        for (int i = 0; i < int'(HB); i++) begin
            if (r_q.out_cnt == OCW'(i)) begin
                out_byte = r_q.hash[int'(Nk) - 1 - 8 * i -: 8];
            end
        end
    end

    // Buffer presented to the core as a byte array, byte 0 first received.
    always_comb begin
        for (int i = 0; i < int'(Nl); i++) begin
            Sha_Data[i] = r_q.buffer[i];
        end
    end

    // Output decodes of the registered state.
    always_comb begin
        In_Ready   = in_open;
        Out_Valid  = (r_q.state == SEND);
        Out_Data   = out_byte;
        Out_Last   = out_last;
        Sha_Enable = (r_q.state == START);
        Busy       = (r_q.state != COLLECT);
    end

endmodule

// File: tb/tb_sha_stream.sv
// Directed bench for sha_stream: a Nl=3 instance with a behavioural core and
// a Nl=64 instance whose core handshake is driven by hand.
module tb_sha_stream;

    localparam int unsigned NL0 = 3;
    localparam int unsigned NL1 = 64;
    localparam int unsigned NK  = 256;

    localparam logic [255:0] ABC_H =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] H1 =
        256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // instance 0 (Nl=3)
    logic [7:0]   in_data0   = 8'h00;
    logic         in_valid0  = 1'b0;
    logic         in_ready0;
    logic [7:0]   out_data0;
    logic         out_valid0;
    logic         out_ready0 = 1'b0;
    logic         out_last0;
    logic [7:0]   sha_data0 [0:NL0-1];
    logic         sha_en0;
    logic [255:0] hash0;
    logic         rdy0;
    logic         busy0;
    logic         force_rdy0 = 1'b0;

    // instance 1 (Nl=64)
    logic [7:0]   in_data1   = 8'h00;
    logic         in_valid1  = 1'b1;
    logic         in_ready1;
    logic [7:0]   out_data1;
    logic         out_valid1;
    logic         out_ready1 = 1'b0;
    logic         out_last1;
    logic [7:0]   sha_data1 [0:NL1-1];
    logic         sha_en1;
    logic [255:0] hash1      = H1;
    logic         sha_rdy1   = 1'b0;
    logic         busy1;

    sha_stream #(.Nl(NL0), .Nk(NK)) u0 (
        .clk(clk), .rst(rst),
        .In_Data(in_data0), .In_Valid(in_valid0), .In_Ready(in_ready0),
        .Out_Data(out_data0), .Out_Valid(out_valid0), .Out_Ready(out_ready0),
        .Out_Last(out_last0), .Sha_Data(sha_data0), .Sha_Enable(sha_en0),
        .Sha_Hash(hash0), .Sha_Ready(rdy0), .Busy(busy0)
    );

    sha_stream #(.Nl(NL1), .Nk(NK)) u1 (
        .clk(clk), .rst(rst),
        .In_Data(in_data1), .In_Valid(in_valid1), .In_Ready(in_ready1),
        .Out_Data(out_data1), .Out_Valid(out_valid1), .Out_Ready(out_ready1),
        .Out_Last(out_last1), .Sha_Data(sha_data1), .Sha_Enable(sha_en1),
        .Sha_Hash(hash1), .Sha_Ready(sha_rdy1), .Busy(busy1)
    );

    // Behavioural core digest: real SHA-256 for "abc", a byte pattern otherwise.
    function automatic logic [255:0] core_model(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c);
        logic [255:0] h;
        logic [7:0]   d [3];
        h = '0;
        if (a == 8'h61 && b == 8'h62 && c == 8'h63) return ABC_H;
        d[0] = a; d[1] = b; d[2] = c;
        for (int i = 0; i < 32; i++) h = {h[247:0], d[i % 3] ^ 8'(i)};
        return h;
    endfunction

    // Core for instance 0: answers each Enable with a Ready pulse five cycles on.
    int           en_cnt     = 0;
    int           en_cyc     = 0;
    int           core_timer = 0;
    logic         core_rdy   = 1'b0;
    logic [255:0] core_hash  = '0;
    always @(posedge clk) begin
        core_rdy <= 1'b0;
        if (rst) begin
            core_timer <= 0;
        end else if (sha_en0) begin
            en_cnt     <= en_cnt + 1;
            en_cyc     <= cyc;
            core_hash  <= core_model(sha_data0[0], sha_data0[1], sha_data0[2]);
            core_timer <= 4;
        end else if (core_timer == 1) begin
            core_rdy   <= 1'b1;
            core_timer <= 0;
        end else if (core_timer > 1) begin
            core_timer <= core_timer - 1;
        end
    end
    assign rdy0  = core_rdy | force_rdy0;
    assign hash0 = core_hash;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] tx_q [$];
    logic [7:0] exp_q [$];
    int         lastcyc_q [$];
    int         out_idx     = 0;
    int         last_in_cyc = 0;

    task automatic push_digest(input logic [255:0] h);
        for (int i = 0; i < 32; i++) exp_q.push_back(8'(h >> (8 * (31 - i))));
    endtask

    // Cycle loop for instance 0: feeds tx_q, drains and checks against exp_q.
    task automatic stream(input int budget, input bit stall);
        int         k      = 0;
        bit         held_v = 1'b0;
        logic [7:0] held   = 8'h00;
        logic [7:0] e;
        int         pat [4] = '{1, 0, 0, 1};
        while ((tx_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
            in_valid0  = (tx_q.size() != 0);
            in_data0   = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
            out_ready0 = stall ? (pat[k % 4] == 1) : 1'b1;
            if (held_v) begin
                check("hold_valid", 32'(out_valid0), 32'd1);
                check("hold_data", 32'(out_data0), 32'(held));
            end
            if (out_valid0 && out_ready0) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data0), 32'(e));
                    check("out_last", 32'(out_last0), 32'(out_idx % 32 == 31));
                    if (out_idx % 32 == 31) lastcyc_q.push_back(cyc);
                    out_idx++;
                end
            end
            held_v = out_valid0 && !out_ready0;
            held   = out_data0;
            if (in_valid0 && in_ready0) begin
                void'(tx_q.pop_front());
                last_in_cyc = cyc;
            end
            step();
            k++;
        end
        in_valid0  = 1'b0;
        out_ready0 = 1'b0;
        check("stream_budget", 32'(k < budget), 32'd1);
    endtask

    // Instance 1: push n bytes with value base+j, waiting for In_Ready.
    task automatic u1_feed(input int n, input int base);
        int t;
        for (int j = 0; j < n; j++) begin
            in_valid1 = 1'b1;
            in_data1  = 8'(base + j);
            t = 0;
            while (!in_ready1 && t < 20) begin
                step();
                t++;
            end
            check("u1_feed_wait", 32'(t < 20), 32'd1);
            step();
        end
        in_valid1 = 1'b0;
    endtask

    // Instance 1: pulse Ready with h, then drain and check all 32 bytes.
    task automatic u1_drain(input logic [255:0] h);
        hash1    = h;
        sha_rdy1 = 1'b1;
        step();
        sha_rdy1 = 1'b0;
        check("u1_send_valid", 32'(out_valid1), 32'd1);
        check("u1_send_in_ready", 32'(in_ready1), 32'd1);
        out_ready1 = 1'b1;
        for (int j = 0; j < 32; j++) begin
            check("u1_out_data", 32'(out_data1), 32'(8'(h >> (8 * (31 - j)))));
            check("u1_out_last", 32'(out_last1), 32'(j == 31));
            step();
        end
        out_ready1 = 1'b0;
        check("u1_done_valid", 32'(out_valid1), 32'd0);
        check("u1_done_busy", 32'(busy1), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_hi;
        int en_before;
        int k;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset values
        check("rst_in_ready", 32'(in_ready0), 32'd1);
        check("rst_out_valid", 32'(out_valid0), 32'd0);
        check("rst_out_last", 32'(out_last0), 32'd0);
        check("rst_sha_en", 32'(sha_en0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_sha_data", 32'({sha_data0[0], sha_data0[1], sha_data0[2]}), 32'd0);

        // Nl=64 with In_Valid held high from reset
        n_hi = 0;
        for (int i = 0; i < 64; i++) begin
            in_data1 = 8'(i);
            if (in_ready1) n_hi++;
            step();
        end
        check("u1_ready_cycles", 32'(n_hi), 32'd64);
        check("u1_full_in_ready", 32'(in_ready1), 32'd0);
        check("u1_full_busy", 32'(busy1), 32'd0);
        check("u1_full_en", 32'(sha_en1), 32'd0);
        step();
        check("u1_start_en", 32'(sha_en1), 32'd1);
        check("u1_start_busy", 32'(busy1), 32'd1);
        check("u1_start_in_ready", 32'(in_ready1), 32'd0);
        check("u1_data0", 32'(sha_data1[0]), 32'd0);
        check("u1_data10", 32'(sha_data1[10]), 32'd10);
        check("u1_data63", 32'(sha_data1[63]), 32'd63);
        step();
        in_valid1 = 1'b0;
        check("u1_wait_en", 32'(sha_en1), 32'd0);
        for (int i = 0; i < 2; i++) begin
            check("u1_wait_in_ready", 32'(in_ready1), 32'd0);
            check("u1_wait_out_valid", 32'(out_valid1), 32'd0);
            step();
        end
        u1_drain(H1);

        // Ready pulse during COLLECT with 10 bytes buffered is ignored
        u1_feed(10, 0);
        sha_rdy1 = 1'b1;
        step();
        sha_rdy1 = 1'b0;
        check("u1_stale_valid", 32'(out_valid1), 32'd0);
        check("u1_stale_busy", 32'(busy1), 32'd0);
        check("u1_stale_in_ready", 32'(in_ready1), 32'd1);
        u1_feed(54, 10);
        check("u1_b_full_en", 32'(sha_en1), 32'd0);
        step();
        check("u1_b_start_en", 32'(sha_en1), 32'd1);
        check("u1_b_data9", 32'(sha_data1[9]), 32'd9);
        check("u1_b_data10", 32'(sha_data1[10]), 32'd10);
        check("u1_b_data63", 32'(sha_data1[63]), 32'd63);
        step();
        u1_drain(~H1);

        // "abc" through the behavioural core
        en_before = en_cnt;
        tx_q = '{8'h61, 8'h62, 8'h63};
        push_digest(ABC_H);
        stream(200, 1'b0);
        check("abc_en_count", 32'(en_cnt - en_before), 32'd1);
        check("abc_en_latency", 32'(en_cyc - last_in_cyc), 32'd2);
        check("abc_end_valid", 32'(out_valid0), 32'd0);
        check("abc_end_busy", 32'(busy0), 32'd0);

        // stalled drain with the second message collected during SEND
        en_before = en_cnt;
        lastcyc_q.delete();
        tx_q = '{8'h61, 8'h62, 8'h63, 8'h10, 8'h20, 8'h30};
        push_digest(ABC_H);
        push_digest(core_model(8'h10, 8'h20, 8'h30));
        stream(600, 1'b1);
        check("ovl_en_count", 32'(en_cnt - en_before), 32'd2);
        check("ovl_last_count", 32'(lastcyc_q.size()), 32'd2);
        check("ovl_start_follows",
              32'(en_cyc), 32'(lastcyc_q.size() > 0 ? lastcyc_q[0] + 1 : -1));
        check("ovl_end_valid", 32'(out_valid0), 32'd0);

        // reset in WAIT, then a stale Ready pulse
        en_before = en_cnt;
        tx_q = '{8'h61, 8'h62, 8'h63};
        stream(50, 1'b0);
        k = 0;
        while (en_cnt == en_before && k < 20) begin
            step();
            k++;
        end
        check("rw_en_seen", 32'(en_cnt - en_before), 32'd1);
        check("rw_in_wait", 32'(busy0), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (2) step();
        force_rdy0 = 1'b1;
        step();
        force_rdy0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rw_out_valid", 32'(out_valid0), 32'd0);
            check("rw_busy", 32'(busy0), 32'd0);
            check("rw_in_ready", 32'(in_ready0), 32'd1);
            check("rw_sha_en", 32'(sha_en0), 32'd0);
            step();
        end
        check("rw_en_count", 32'(en_cnt - en_before), 32'd1);
        tx_q = '{8'h61, 8'h62, 8'h63};
        push_digest(ABC_H);
        stream(200, 1'b0);
        check("rw_next_en_count", 32'(en_cnt - en_before), 32'd2);
        check("rw_next_latency", 32'(en_cyc - last_in_cyc), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sha_stream.md
Name: sha_stream

Overview:
- Byte-stream front end and initiator for the sha hashing core.
- Collects exactly Nl message bytes over a valid/ready input stream into a byte buffer, then drives the core's Data array and issues a one-cycle Enable.
- Waits for the core's one-cycle Ready pulse, captures Hash, and serialises the digest MSB-first over a valid/ready output stream.
- Sits between a host/DMA byte interface and the sha core.

Parameters:
- Nl, 64, message length in bytes; matches sha_const::Nl.
- Nk, 256, digest width in bits; matches sha_const::Nk. Legal values: 160, 256, 512.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- In_Data  input  8  message byte.
- In_Valid  input  1  In_Data valid.
- In_Ready  output  1  buffer accepts byte; transfer occurs when In_Valid && In_Ready.
- Out_Data  output  8  digest byte.
- Out_Valid  output  1  Out_Data valid.
- Out_Ready  input  1  sink accepts byte.
- Out_Last  output  1  marks final digest byte (byte Nk/8-1).
- Sha_Data  output  8 x Nl  unpacked byte array [0:Nl-1] to the core; byte 0 is the first received.
- Sha_Enable  output  1  start pulse to the core.
- Sha_Hash  input  Nk  digest from the core.
- Sha_Ready  input  1  one-cycle digest-valid pulse from the core.
- Busy  output  1  high whenever state != COLLECT.

Behaviour:
- Reset (rst=1 at posedge): state=COLLECT, in_cnt=0, out_cnt=0, buffer cleared to 0, hash register cleared to 0.
- Reset output values: In_Ready=1, Out_Valid=0, Out_Last=0, Sha_Enable=0, Busy=0, Sha_Data all 0.
- States: COLLECT, START, WAIT, SEND.
- COLLECT:
  - In_Ready = (in_cnt < Nl).
  - Each accepted byte is written to buffer[in_cnt], and in_cnt increments.
  - When in_cnt reaches Nl, go to START on the next cycle. No further bytes are accepted.
- START:
  - Sha_Enable=1 for exactly one cycle, then go to WAIT.
  - In_Ready=0.
- WAIT:
  - In_Ready=0. Buffer must stay stable because the core reads Data over many cycles.
  - On Sha_Ready=1: latch Sha_Hash into the hash register, clear in_cnt, clear out_cnt, go to SEND.
- SEND:
  - Out_Valid=1 and Out_Data = hash[Nk-1-8*out_cnt -: 8].
  - On Out_Valid && Out_Ready, out_cnt increments.
  - Out_Last = (out_cnt == Nk/8-1). When the last byte is accepted, go to COLLECT.
  - Output holds Out_Data stable while Out_Ready=0 (AXI-stream rules).
  - Input overlap: In_Ready = (in_cnt < Nl), so the next message may be collected while the digest drains.
  - On leaving SEND with in_cnt == Nl, go directly to START; otherwise go to COLLECT with in_cnt preserved.
- Latency: last input byte accepted at cycle t → Sha_Enable at t+2. Sha_Ready at cycle s → first Out_Valid at s+1.
- Sha_Ready outside WAIT is ignored (e.g. a stale pulse after reset mid-hash).
- Sha_Enable is never asserted outside START, and never twice per message.
- Reset mid-operation: all state is discarded and nothing is emitted. The core is reset by the same system reset domain.
- Counter widths: in_cnt is $clog2(Nl+1) bits; out_cnt is $clog2(Nk/8) bits. No wrap: counters are cleared explicitly.

Decomposition:
- Nl and Nk come from sha_const as parameter defaults.
- Add to sha_const:
  - a stream_state_t enum (COLLECT, START, WAIT, SEND), 2 bits;
  - a localparam Nh = Nk/8.
- Single module. No sub-module; the serialiser is a muxed shift and is not worth separating.
- Registers are held in a packed reg_type struct updated from an always_comb next-state block.

Test Plan:
- Nl=3, Nk=256: stream "abc" (0x61,0x62,0x63) with a behavioural core returning SHA-256 → Sha_Enable pulses once, 2 cycles after 0x63. Out emits ba 78 16 bf 8f 01 cf ea 41 41 40 de 5d ae 22 23 b0 03 61 a3 96 17 7a 9c b4 10 ff 61 f2 00 15 ad; Out_Last only on 0xad.
- Out_Ready toggles 1,0,0,1 during SEND → Out_Data held constant while stalled; exactly 32 bytes delivered, none duplicated.
- In_Valid held high from reset with Nl=64 → In_Ready falls after byte 64. In_Ready stays 0 through START/WAIT and rises on the first SEND cycle.
- Second message fully streamed during SEND of the first → START immediately follows the last Out transfer. Second digest is correct.
- rst asserted in WAIT, then spurious Sha_Ready 3 cycles later → state COLLECT, Out_Valid stays 0, in_cnt=0, no Sha_Enable.
- Sha_Ready pulsed during COLLECT with partial message (in_cnt=10) → ignored; collection continues to Nl normally.
